// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (optional macro: DIV_EARLY_OUT_EN)
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              es_valid,
   input  logic              es_div,
   input  logic              es_divu,
   input  logic [DATA_W-1:0] es_src1,
   input  logic [DATA_W-1:0] es_src2,
   input  logic              exc_flush,
   output logic              div_block,
   output logic              div_done,
   output logic [DATA_W-1:0] div_lo,
   output logic [DATA_W-1:0] div_hi
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic              sgn_q, sgn_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              dz_q, dz_d;

   logic              req;
   logic [DATA_W-1:0] abs1, abs2;
   logic [DATA_W:0]   rem_sh, diff;
   logic              ge;
   logic [DATA_W-1:0] rem_nx, quo_nx;
   logic [DATA_W-1:0] fin_lo, fin_hi;

   assign req = es_valid & (es_div | es_divu) & ~exc_flush;

   // Operand magnitudes: only a signed divide takes absolute values
   assign abs1 = (es_div & es_src1[DATA_W-1]) ? -es_src1 : es_src1;
   assign abs2 = (es_div & es_src2[DATA_W-1]) ? -es_src2 : es_src2;

   // One restoring step: the partial remainder stays below the divisor,
   // so the shifted value fits DATA_W+1 bits and the borrow is diff's MSB
   assign rem_sh = {rem_q, quo_q[DATA_W-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign ge     = ~diff[DATA_W];
   assign rem_nx = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
   assign quo_nx = {quo_q[DATA_W-2:0], ge};

   // Sign correction of the final step; divide by zero forces an all-ones
   // quotient, the remainder naturally ends up equal to the dividend
   assign fin_lo = dz_q ? '1 : ((sgn_q & qneg_q) ? -quo_nx : quo_nx);
   assign fin_hi = (sgn_q & rneg_q) ? -rem_nx : rem_nx;

   assign div_lo = lo_q;
   assign div_hi = hi_q;

   // Next-state, datapath updates and stall/done outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      sgn_d     = sgn_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      dz_d      = dz_q;
      div_block = 1'b0;
      div_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               div_block = 1'b1;
               sgn_d     = es_div;
               qneg_d    = es_src1[DATA_W-1] ^ es_src2[DATA_W-1];
               rneg_d    = es_src1[DATA_W-1];
               dz_d      = (es_src2 == '0);
               quo_d     = abs1;
               dvs_d     = abs2;
               rem_d     = '0;
               cnt_d     = CNT_W'(DATA_W);
`ifdef DIV_EARLY_OUT_EN
               if (abs1 < abs2) begin
                  state_d = DONE;
                  lo_d    = '0;
                  hi_d    = es_src1;
               end else begin
                  state_d = CALC;
               end
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            div_block = 1'b1;
            rem_d     = rem_nx;
            quo_d     = quo_nx;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               lo_d    = fin_lo;
               hi_d    = fin_hi;
            end
         end
         DONE: begin
            div_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A flush abandons the divide and leaves the visible results alone
      if (exc_flush) begin
         state_d   = IDLE;
         lo_d      = lo_q;
         hi_d      = hi_q;
         div_block = 1'b0;
         div_done  = 1'b0;
      end
      if (reset) begin
         div_block = 1'b0;
         div_done  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;

   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         es_valid, es_div, es_divu, exc_flush;
   logic [W-1:0] es_src1, es_src2;
   logic         div_block, div_done;
   logic [W-1:0] div_lo, div_hi;

   int n_pass = 0;
   int n_total = 0;

   div_unit #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset), .es_valid(es_valid), .es_div(es_div),
      .es_divu(es_divu), .es_src1(es_src1), .es_src2(es_src2),
      .exc_flush(exc_flush), .div_block(div_block), .div_done(div_done),
      .div_lo(div_lo), .div_hi(div_hi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         d;
      logic         du;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      bit           early;
      string        name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
   endtask

   // Issue one divide at the next negedge; cycle c is sampled 1 time unit
   // after the c-th negedge. Operands are scrambled once the request is gone.
   task automatic do_div(input logic d, input logic du, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat, output int blk,
                         output logic [W-1:0] lo, output logic [W-1:0] hi);
      @(negedge clk);
      es_valid = 1'b1; es_div = d; es_divu = du; es_src1 = a; es_src2 = b;
      lat = -1; blk = 0; lo = '0; hi = '0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (div_block) blk++;
         if (div_done) begin
            lat = c; lo = div_lo; hi = div_hi;
            break;
         end
         @(negedge clk);
         es_valid = 1'b0; es_src1 = $urandom; es_src2 = $urandom;
      end
   endtask

   function automatic int exp_lat(input bit early);
      return (EARLY_EN && early) ? 1 : 33;
   endfunction

   initial begin
      int lat, blk, ndone;
      logic [W-1:0] lo, hi;

      vecs[0]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, "divu_100_7"};
      vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "div_m7_2"};
      vecs[2]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, "div_min_m1"};
      vecs[3]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, "divu_5_0"};
      vecs[4]  = '{1'b0, 1'b1, 32'd3,        32'd10,       32'd0,        32'd3,        1'b1, "divu_3_10"};
      vecs[5]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, "div_7_m2"};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, "div_m7_0"};
      vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b1, "div_m3_10"};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, "divu_max_1"};
      vecs[9]  = '{1'b0, 1'b1, 32'd0,        32'd5,        32'd0,        32'd0,        1'b1, "divu_0_5"};
      vecs[10] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "both_div_prio"};
      vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, "divu_big_2"};

      // Reset with a request pending: nothing may leak out
      reset = 1'b1; exc_flush = 1'b0;
      es_valid = 1'b1; es_div = 1'b0; es_divu = 1'b1; es_src1 = 32'd9; es_src2 = 32'd3;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_block", {31'd0, div_block}, 32'd0);
      chk("rst_done",  {31'd0, div_done},  32'd0);
      chk("rst_lo", div_lo, 32'd0);
      chk("rst_hi", div_hi, 32'd0);
      @(negedge clk);
      reset = 1'b0; es_valid = 1'b0;

      foreach (vecs[i]) begin
         do_div(vecs[i].d, vecs[i].du, vecs[i].a, vecs[i].b, lat, blk, lo, hi);
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].early)));
         chk({vecs[i].name, "_blk"}, 32'(blk), 32'(exp_lat(vecs[i].early)));
         chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
         chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      end

      // Back-to-back: second request presented the cycle after DONE
      do_div(1'b0, 1'b1, 32'd9, 32'd3, lat, blk, lo, hi);
      chk("b2b1_lat", 32'(lat), 32'd33);
      chk("b2b1_blk", 32'(blk), 32'd33);
      chk("b2b1_lo", lo, 32'd3);
      chk("b2b1_hi", hi, 32'd0);
      do_div(1'b0, 1'b1, 32'd10, 32'd4, lat, blk, lo, hi);
      chk("b2b2_lat", 32'(lat), 32'd33);
      chk("b2b2_blk", 32'(blk), 32'd33);
      chk("b2b2_lo", lo, 32'd2);
      chk("b2b2_hi", hi, 32'd2);

      // Flush at cycle 10 of DIV 1000/3: results must stay at 2/2
      @(negedge clk);
      es_valid = 1'b1; es_div = 1'b1; es_divu = 1'b0; es_src1 = 32'd1000; es_src2 = 32'd3;
      ndone = 0;
      for (int c = 0; c < 50; c++) begin
         if (c == 10) exc_flush = 1'b1;
         if (c == 11) exc_flush = 1'b0;
         #1;
         if (div_done) ndone++;
         if (c == 9)  chk("flush_blk_c9",  {31'd0, div_block}, 32'd1);
         if (c == 10) chk("flush_blk_c10", {31'd0, div_block}, 32'd0);
         if (c == 11) chk("flush_blk_c11", {31'd0, div_block}, 32'd0);
         @(negedge clk);
         es_valid = 1'b0;
      end
      chk("flush_no_done", 32'(ndone), 32'd0);
      chk("flush_lo_kept", div_lo, 32'd2);
      chk("flush_hi_kept", div_hi, 32'd2);

      // Request in the same cycle as a flush is ignored
      es_valid = 1'b1; es_div = 1'b0; es_divu = 1'b1; es_src1 = 32'd100; es_src2 = 32'd7;
      exc_flush = 1'b1;
      #1;
      chk("flreq_blk_c0", {31'd0, div_block}, 32'd0);
      @(negedge clk);
      es_valid = 1'b0; exc_flush = 1'b0;
      ndone = 0;
      for (int c = 1; c < 45; c++) begin
         #1;
         if (c == 1) chk("flreq_blk_c1", {31'd0, div_block}, 32'd0);
         if (div_done) ndone++;
         @(negedge clk);
      end
      chk("flreq_no_done", 32'(ndone), 32'd0);

      // Reset in the middle of CALC
      es_valid = 1'b1; es_div = 1'b0; es_divu = 1'b1; es_src1 = 32'd100; es_src2 = 32'd7;
      ndone = 0;
      for (int c = 0; c < 45; c++) begin
         if (c == 5) reset = 1'b1;
         if (c == 6) reset = 1'b0;
         #1;
         if (div_done) ndone++;
         if (c == 5) chk("midrst_blk", {31'd0, div_block}, 32'd0);
         if (c == 6) begin
            chk("midrst_lo", div_lo, 32'd0);
            chk("midrst_hi", div_hi, 32'd0);
            chk("midrst_blk_after", {31'd0, div_block}, 32'd0);
         end
         @(negedge clk);
         es_valid = 1'b0;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);

      // Normal operation resumes
      do_div(1'b0, 1'b1, 32'd100, 32'd7, lat, blk, lo, hi);
      chk("again_lat", 32'(lat), 32'd33);
      chk("again_lo", lo, 32'd14);
      chk("again_hi", hi, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
